kftvga_text_video_engine: RTL and testbench
===========================================

Name: kftvga_text_video_engine

Overview:
Parametrised text-mode VGA engine and successor to the fixed 640x480 controller. Generates programmable H/V timing, fetches character/attribute and glyph data through a fixed-latency VRAM/char-ROM port, and outputs 12-bit RGB. Adds a pipelined fetch with aligned syncs, a border colour, a hardware cursor, attribute blink, and data-enable/frame-start outputs.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 400, active lines per frame
V_FP, 12, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 35, vertical back porch
H_SYNC_POL, 0, asserted level of h_sync
V_SYNC_POL, 1, asserted level of v_sync
CHAR_W, 8, glyph width (pixels); char_line_data width
CHAR_H, 16, glyph height (lines)
COLS, 80, text columns
ROWS, 25, text rows
ADDR_W, 13, vram_address width
VRAM_LATENCY, 1, cycles from address to returned data (>=1)
BLINK_EN, 1, 1: attr[7] is blink, background 8 colours; 0: attr[7:4] is 16-colour background

Ports:
video_clock  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high
vram_address  out  ADDR_W  cell address = row*COLS+col
char_line_number  out  clog2(CHAR_H)  glyph line within cell
char_line_data  in  CHAR_W  glyph bits, MSB = leftmost pixel
char_color_data  in  8  attribute: [3:0] fg, [7:4] bg/blink
cursor_enable  in  1  cursor on
cursor_col  in  8  cursor column
cursor_row  in  8  cursor row
cursor_start  in  clog2(CHAR_H)  first cursor glyph line
cursor_end  in  clog2(CHAR_H)  last cursor glyph line
border_color  in  4  palette index outside text area
video_h_sync  out  1  horizontal sync
video_v_sync  out  1  vertical sync
video_de  out  1  active-video enable
frame_start  out  1  one-cycle pulse at first active pixel of frame
video_r/g/b  out  4 each  colour

Behaviour:
- Counters: h 0..H_TOTAL-1 (H_TOTAL=sum of H_*), v increments when h wraps, 0..V_TOTAL-1, wraps to 0. Order per line/frame: active, front porch, sync, back porch.
- Stage 0 (combinational from counters): h<H_ACTIVE and v<V_ACTIVE = active. col=h/CHAR_W, dot=h%CHAR_W, row=v/CHAR_H, line=v%CHAR_H. vram_address=row*COLS+col, truncated to ADDR_W; char_line_number=line; both 0 outside the text area.
- Text area: col<COLS and row<ROWS inside active region; other active pixels show border_color.
- Data returns exactly VRAM_LATENCY cycles after address; dot, active, text-area, cursor-hit and sync flags are delayed to match. Output register adds 1 cycle: all outputs for counter state (h,v) appear VRAM_LATENCY+1 cycles later, syncs and de included.
- Sync: asserted (=POL) when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), resp. v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); otherwise !POL.
- Palette (index->RGB): 0 000, 1 008, 2 080, 3 088, 4 800, 5 808, 6 880, 7 CCC, 8 888, 9 00F, A 0F0, B 0FF, C F00, D F0F, E FF0, F FFF.
- Blink counter: 6-bit frame_cnt, increments when v wraps to 0. Text blink phase = frame_cnt[5]; cursor phase = frame_cnt[4].
- Pixel: fg_on = char_line_data[CHAR_W-1-dot]. If BLINK_EN and attr[7] and frame_cnt[5]=1, fg_on forced 0; bg = {1'b0,attr[6:4]}. Cursor hit (cursor_enable, col==cursor_col, row==cursor_row, cursor_start<=line<=cursor_end, frame_cnt[4]=0) forces fg_on=1. Output fg colour if fg_on, else bg colour.
- Blanking: rgb=0, video_de=0. Border: de=1, rgb=palette(border_color).
- frame_start: 1 for the output cycle of (h=0,v=0), else 0.
- Cursor registers are sampled at stage 0; changes take effect on the next pixel fetched.
- Reset (any time, including mid-frame): h=v=0, frame_cnt=0, pipeline cleared. Outputs: syncs=!POL, rgb=0, de=0, frame_start=0, vram_address=0, char_line_number=0. The first frame_start occurs VRAM_LATENCY+1 cycles after reset release.

Test Plan:
- Defaults, run 2 frames -> h_sync period 800 clk with low width 96; v_sync period 449 lines with high width 2 lines; de high for 640 clk per line on 400 lines.
- VRAM_LATENCY=3, glyph 8'h80, attr 8'h1E at cell 0 -> first pixel yellow FF0 4 cycles after (0,0), next 7 pixels blue 008; h_sync edge also delayed 4 cycles.
- COLS=40, border_color=4 -> pixels 320..639 of each active line are 800, de=1.
- attr 8'h9F, BLINK_EN=1 -> fg FFF for frames 0-31; frames 32-63 show bg 008 only.
- Cursor at (row 2, col 5), lines 14-15 -> cells 5 of text row 2 show fg on lines 14-15 in frames 0-15, absent in frames 16-31.
- Assert reset at h=300,v=200 for 3 cycles -> outputs at reset values immediately; frame_start pulses 2 cycles after release.

Source files
------------

// File: rtl/kftvga_text_video_engine.sv
// kftvga_text_video_engine: parametrised text-mode VGA engine with pipelined VRAM fetch, border, cursor and blink
// Ports:
//   video_clock, reset                 pixel clock, asynchronous active-high reset
//   vram_address, char_line_number     cell address (row*COLS+col) and glyph line, 0 outside the text area
//   char_line_data, char_color_data    glyph bits (MSB leftmost) and attribute, VRAM_LATENCY cycles after address
//   cursor_*                           cursor enable, cell position and glyph line range
//   border_color                       palette index for active pixels outside the text area
//   video_h_sync, video_v_sync         syncs, aligned with the pixel pipeline
//   video_de, frame_start              active-video enable, pulse at first active pixel of a frame
//   video_r, video_g, video_b          12-bit colour
module kftvga_text_video_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 400,
    parameter int V_FP         = 12,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 35,
    parameter int H_SYNC_POL   = 0,
    parameter int V_SYNC_POL   = 1,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int ADDR_W       = 13,
    parameter int VRAM_LATENCY = 1,
    parameter int BLINK_EN     = 1
) (
    input  logic                      video_clock,
    input  logic                      reset,
    output logic [ADDR_W-1:0]         vram_address,
    output logic [$clog2(CHAR_H)-1:0] char_line_number,
    input  logic [CHAR_W-1:0]         char_line_data,
    input  logic [7:0]                char_color_data,
    input  logic                      cursor_enable,
    input  logic [7:0]                cursor_col,
    input  logic [7:0]                cursor_row,
    input  logic [$clog2(CHAR_H)-1:0] cursor_start,
    input  logic [$clog2(CHAR_H)-1:0] cursor_end,
    input  logic [3:0]                border_color,
    output logic                      video_h_sync,
    output logic                      video_v_sync,
    output logic                      video_de,
    output logic                      frame_start,
    output logic [3:0]                video_r,
    output logic [3:0]                video_g,
    output logic [3:0]                video_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int LW = $clog2(CHAR_H);
    localparam int DW = CHAR_W > 1 ? $clog2(CHAR_W) : 1;
    localparam logic HPOL = 1'(H_SYNC_POL);
    localparam logic VPOL = 1'(V_SYNC_POL);
    localparam logic [11:0] PAL [16] = '{
        12'h000, 12'h008, 12'h080, 12'h088, 12'h800, 12'h808, 12'h880, 12'hCCC,
        12'h888, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF
    };

    typedef struct packed {
        logic          blink;
        logic          fs;
        logic          vs;
        logic          hs;
        logic          cur;
        logic          txt;
        logic          act;
        logic [DW-1:0] dot;
    } stage_t;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [5:0]    frame_cnt;
    logic [31:0]   hx, vx, col, row, line;
    logic          act, txt, cur, fg_bit, fg_on;
    logic [3:0]    bg, idx;
    logic [11:0]   rgb_n;
    stage_t        s0, p;
    stage_t        pipe [VRAM_LATENCY];

    assign hx   = 32'(h);
    assign vx   = 32'(v);
    assign col  = hx / CHAR_W;
    assign row  = vx / CHAR_H;
    assign line = vx % CHAR_H;
    assign act  = hx < H_ACTIVE && vx < V_ACTIVE;
    assign txt  = act && col < COLS && row < ROWS;
    assign cur  = txt && cursor_enable && !frame_cnt[4] && col == 32'(cursor_col) && row == 32'(cursor_row)
                  && line >= 32'(cursor_start) && line <= 32'(cursor_end);
    assign vram_address     = txt ? ADDR_W'(row * COLS + col) : '0;
    assign char_line_number = txt ? LW'(line) : '0;
    assign s0 = {frame_cnt[5], hx == 0 && vx == 0,
                 vx >= V_ACTIVE + V_FP && vx < V_ACTIVE + V_FP + V_SYNC,
                 hx >= H_ACTIVE + H_FP && hx < H_ACTIVE + H_FP + H_SYNC,
                 cur, txt, act, DW'(hx % CHAR_W)};

    always_ff @(posedge video_clock or posedge reset)
        if (reset) begin
            h         <= '0;
            v         <= '0;
            frame_cnt <= '0;
        end else begin
            h <= hx == H_TOTAL - 1 ? '0 : h + 1'b1;
            if (hx == H_TOTAL - 1) begin
                v <= vx == V_TOTAL - 1 ? '0 : v + 1'b1;
                if (vx == V_TOTAL - 1) frame_cnt <= frame_cnt + 1'b1;
            end
        end

    // Flags travel alongside the VRAM request so they line up with the returned data.
    always_ff @(posedge video_clock or posedge reset)
        if (reset) begin
            for (int i = 0; i < VRAM_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= s0;
            for (int i = 1; i < VRAM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end

    assign p      = pipe[VRAM_LATENCY-1];
    assign fg_bit = char_line_data[DW'(CHAR_W - 1) - p.dot];
    // The cursor overrides blink so it stays visible on blinking cells.
    assign fg_on  = p.cur || (fg_bit && !(BLINK_EN != 0 && char_color_data[7] && p.blink));
    assign bg     = BLINK_EN != 0 ? {1'b0, char_color_data[6:4]} : char_color_data[7:4];
    assign idx    = fg_on ? char_color_data[3:0] : bg;
    assign rgb_n  = !p.act ? 12'h000 : PAL[p.txt ? idx : border_color];

    always_ff @(posedge video_clock or posedge reset)
        if (reset) begin
            video_h_sync                  <= ~HPOL;
            video_v_sync                  <= ~VPOL;
            video_de                      <= 1'b0;
            frame_start                   <= 1'b0;
            {video_r, video_g, video_b}   <= '0;
        end else begin
            video_h_sync                  <= p.hs ? HPOL : ~HPOL;
            video_v_sync                  <= p.vs ? VPOL : ~VPOL;
            video_de                      <= p.act;
            frame_start                   <= p.fs;
            {video_r, video_g, video_b}   <= rgb_n;
        end
endmodule

// File: tb/tb_kftvga_text_video_engine.sv
// tb_kftvga_text_video_engine: directed checks on a default-size engine and a small latency-3 engine with border
module tb_kftvga_text_video_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int unsigned cyc;

    logic [12:0] a_addr;
    logic [3:0]  a_line;
    logic [7:0]  a_glyph;
    logic        a_hs, a_vs, a_de, a_fs;
    logic [3:0]  a_r, a_g, a_b;
    logic [11:0] a_rgb;

    logic [3:0]  b_addr;
    logic [0:0]  b_line;
    logic [3:0]  b_q [3];
    logic        b_cur_en;
    logic        b_hs, b_vs, b_de, b_fs;
    logic [3:0]  b_r, b_g, b_b;
    logic [11:0] b_rgb;

    assign a_rgb = {a_r, a_g, a_b};
    assign b_rgb = {b_r, b_g, b_b};

    kftvga_text_video_engine u_a (
        .video_clock(clk), .reset(reset),
        .vram_address(a_addr), .char_line_number(a_line),
        .char_line_data(a_glyph), .char_color_data(8'h1E),
        .cursor_enable(1'b0), .cursor_col(8'd0), .cursor_row(8'd0),
        .cursor_start(4'd0), .cursor_end(4'd0), .border_color(4'h4),
        .video_h_sync(a_hs), .video_v_sync(a_vs), .video_de(a_de), .frame_start(a_fs),
        .video_r(a_r), .video_g(a_g), .video_b(a_b)
    );

    kftvga_text_video_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(0), .CHAR_W(4), .CHAR_H(2),
        .COLS(3), .ROWS(3), .ADDR_W(4), .VRAM_LATENCY(3), .BLINK_EN(1)
    ) u_b (
        .video_clock(clk), .reset(reset),
        .vram_address(b_addr), .char_line_number(b_line),
        .char_line_data(b_q[2]), .char_color_data(8'h9F),
        .cursor_enable(b_cur_en), .cursor_col(8'd1), .cursor_row(8'd2),
        .cursor_start(1'b1), .cursor_end(1'b1), .border_color(4'h4),
        .video_h_sync(b_hs), .video_v_sync(b_vs), .video_de(b_de), .frame_start(b_fs),
        .video_r(b_r), .video_g(b_g), .video_b(b_b)
    );

    // VRAM models: cell 0 line 0 holds 8'h80 on A; cell 4 holds 4'h8 on B, all other B cells 4'hF.
    always @(posedge clk) a_glyph <= (a_addr == 13'd0 && a_line == 4'd0) ? 8'h80 : 8'h00;
    always @(posedge clk) begin
        b_q[0] <= (b_addr == 4'd4) ? 4'h8 : 4'hF;
        b_q[1] <= b_q[0];
        b_q[2] <= b_q[1];
    end

    always @(posedge clk or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic at(input int unsigned k);
        int guard = 0;
        while (cyc < k && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) chk("cycle_sync", cyc, k);
    endtask

    initial begin
        b_cur_en = 1'b1;
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_a_hs", a_hs, 1);
        chk("rst_a_vs", a_vs, 0);
        chk("rst_a_de", a_de, 0);
        chk("rst_a_fs", a_fs, 0);
        chk("rst_a_rgb", a_rgb, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_hs", b_hs, 0);
        chk("rst_b_vs", b_vs, 1);
        reset = 1'b0;

        at(1);     chk("a_fs_k1", a_fs, 0); chk("a_de_k1", a_de, 0);
        at(2);     chk("a_fs_k2", a_fs, 1); chk("a_rgb_first", a_rgb, 12'hFF0); chk("a_de_k2", a_de, 1);
        at(3);     chk("a_fs_k3", a_fs, 0); chk("a_rgb_dot1", a_rgb, 12'h008); chk("b_fs_k3", b_fs, 0); chk("b_de_k3", b_de, 0);
        at(4);     chk("b_fs_k4", b_fs, 1); chk("b_rgb_first", b_rgb, 12'hFFF);
        at(5);     chk("a_addr_h5", a_addr, 0);
        at(8);     chk("a_addr_h8", a_addr, 1);
        at(10);    chk("a_rgb_h8", a_rgb, 12'h008);
        at(12);    chk("b_addr_border", b_addr, 0);
        at(16);    chk("b_rgb_border_h", b_rgb, 12'h800); chk("b_de_border_h", b_de, 1);
        at(20);    chk("b_rgb_blank", b_rgb, 0); chk("b_de_blank", b_de, 0);
        at(21);    chk("b_hs_h17", b_hs, 0);
        at(22);    chk("b_hs_h18", b_hs, 1);
        at(24);    chk("b_hs_h20", b_hs, 1);
        at(25);    chk("b_hs_h21", b_hs, 0);
        at(53);    chk("b_addr_cell4", b_addr, 4); chk("b_line_0", b_line, 0);
        at(56);    chk("b_rgb_cell4_dot0", b_rgb, 12'hFFF);
        at(57);    chk("b_rgb_cell4_dot1", b_rgb, 12'h008);
        at(77);    chk("b_addr_cell4_l1", b_addr, 4); chk("b_line_1", b_line, 1);
        at(80);    chk("b_rgb_cell4_l1", b_rgb, 12'hFFF);
        at(151);   chk("b_rgb_border_v", b_rgb, 12'h800);
        at(219);   chk("b_vs_v8", b_vs, 1);
        at(220);   chk("b_vs_v9", b_vs, 0);
        at(267);   chk("b_vs_v10", b_vs, 0);
        at(268);   chk("b_vs_v11", b_vs, 1);
        at(292);   chk("b_fs_frame1", b_fs, 1);
        at(641);   chk("a_de_h639", a_de, 1);
        at(642);   chk("a_de_h640", a_de, 0); chk("a_rgb_h640", a_rgb, 0);
        at(657);   chk("a_hs_h655", a_hs, 1);
        at(658);   chk("a_hs_h656", a_hs, 0);
        at(753);   chk("a_hs_h751", a_hs, 0);
        at(754);   chk("a_hs_h752", a_hs, 1);
        at(801);   chk("a_line_v1", a_line, 1); chk("a_addr_v1", a_addr, 0);
        at(802);   chk("a_rgb_v1", a_rgb, 12'h008);
        at(1457);  chk("a_hs_l1_h655", a_hs, 1);
        at(1458);  chk("a_hs_l1_h656", a_hs, 0);
        at(8932);  chk("b_frame31_fg", b_rgb, 12'hFFF);
        at(9321);  chk("b_f32_line0", b_rgb, 12'h008);
        at(9345);  chk("b_f32_cursor", b_rgb, 12'hFFF);
        at(9349);  chk("b_f32_col2", b_rgb, 12'h008);
        at(11520); b_cur_en = 1'b0;
        at(11649); chk("b_f40_cursor_off", b_rgb, 12'h008);
        at(12672); b_cur_en = 1'b1;
        at(12808); chk("a_addr_81", a_addr, 81); chk("a_line_v16", a_line, 0);
        at(13953); chk("b_f48_cursor_phase", b_rgb, 12'h008);
        at(18148); chk("b_f63_blink", b_rgb, 12'h008);
        at(18436); chk("b_f64_wrap", b_rgb, 12'hFFF);

        at(19500); chk("a_de_pre_reset", a_de, 1); chk("a_addr_pre_reset", a_addr, 117);
        reset = 1'b1;
        #1;
        chk("mid_a_hs", a_hs, 1);
        chk("mid_a_de", a_de, 0);
        chk("mid_a_rgb", a_rgb, 0);
        chk("mid_a_fs", a_fs, 0);
        chk("mid_a_addr", a_addr, 0);
        chk("mid_a_line", a_line, 0);
        chk("mid_b_hs", b_hs, 0);
        chk("mid_b_vs", b_vs, 1);
        chk("mid_b_de", b_de, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        at(1);     chk("post_a_fs_k1", a_fs, 0);
        at(2);     chk("post_a_fs_k2", a_fs, 1); chk("post_a_rgb", a_rgb, 12'hFF0);
        at(3);     chk("post_b_fs_k3", b_fs, 0);
        at(4);     chk("post_b_fs_k4", b_fs, 1); chk("post_b_rgb", b_rgb, 12'hFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
